// File: rtl/mic_seq_if.sv
// Sequencer bus: control-store fields, ALU flags and MBR in; registered MPC and
// return-stack status out. The master drives the microinstruction side; the
// slave is the sequencer.
interface mic_seq_if #(
  parameter int ADDR_W      = 9,
  parameter int MBR_W       = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              advance;
  logic              N;
  logic              Z;
  logic [MBR_W-1:0]  inMBR;
  logic [ADDR_W-1:0] ADDR;
  logic [2:0]        JNZC;
  logic [1:0]        SEQ_OP;
  logic [ADDR_W-1:0] LINK;
  logic [ADDR_W-1:0] outMPC;
  logic [SP_W-1:0]   sp;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output advance, N, Z, inMBR, ADDR, JNZC, SEQ_OP, LINK,
    input  outMPC, sp, stack_ovf, stack_unf
  );

  modport slave (
    input  advance, N, Z, inMBR, ADDR, JNZC, SEQ_OP, LINK,
    output outMPC, sp, stack_ovf, stack_unf
  );
endinterface

// File: rtl/mic_sequencer.sv
// Registered microprogram sequencer: JMPC/JAM target formation, stall, and a
// LIFO return stack for microsubroutine CALL/RET with sticky error flags.
module mic_sequencer #(
  parameter int                ADDR_W      = 9,
  parameter int                MBR_W       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic     clk,
  input  logic     rst,
  mic_seq_if.slave bus
);
  localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_CALL  = 2'b01,
    OP_RET   = 2'b10,
    OP_FLUSH = 2'b11
  } seq_op_e;

  typedef struct packed {
    logic jamn;
    logic jamz;
    logic jmpc;
  } jnzc_t;

  jnzc_t   jnzc;
  seq_op_e op;

  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] target;
  logic [IDX_W-1:0]  push_idx, top_idx;

  // Stack storage is not reset; only sp decides which entries are live.
  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_q;

  assign jnzc = jnzc_t'(bus.JNZC);
  assign op   = seq_op_e'(bus.SEQ_OP);

  // push writes the slot at sp, pop reads the one below; both only used in range
  assign push_idx = sp_q[IDX_W-1:0];
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));

  // Target: MBR ORs into the low byte, JAM flags OR into the top bit, no priority.
  always_comb begin
    target              = bus.ADDR;
    target[MBR_W-1:0]   = bus.ADDR[MBR_W-1:0] | (jnzc.jmpc ? bus.inMBR : '0);
    target[ADDR_W-1]    = bus.ADDR[ADDR_W-1] | (jnzc.jamn & bus.N) | (jnzc.jamz & bus.Z);
  end

  // Next-state decode of SEQ_OP; advance=0 leaves everything at its current value.
  always_comb begin
    mpc_d = mpc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (bus.advance) begin
      case (op)
        OP_NONE: mpc_d = target;
        OP_CALL: begin
          mpc_d = target;
          if (sp_q < SP_FULL) begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (sp_q != '0) begin
            mpc_d = stack_q[top_idx];
            sp_d  = sp_q - SP_W'(1);
          end else begin
            mpc_d = RESET_ADDR;
            unf_d = 1'b1;
          end
        end
        OP_FLUSH: begin
          mpc_d = target;
          sp_d  = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Control state register; reset wins over advance and SEQ_OP.
  always_ff @(posedge clk) begin
    if (rst) begin
      mpc_q <= RESET_ADDR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mpc_q <= mpc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-stack write on a non-overflowing CALL; suppressed during reset.
  always_ff @(posedge clk) begin
    if (push && !rst) stack_q[push_idx] <= bus.LINK;
  end

  assign bus.outMPC    = mpc_q;
  assign bus.sp        = sp_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_mic_sequencer.sv
// Bench for mic_sequencer: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_mic_sequencer;
  localparam int AW = 9;
  localparam int MW = 8;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mic_seq_if #(.ADDR_W(AW), .MBR_W(MW), .STACK_DEPTH(SD)) bus ();

  mic_sequencer #(.ADDR_W(AW), .MBR_W(MW), .STACK_DEPTH(SD), .RESET_ADDR(9'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a queue, target as plain OR arithmetic.
  int   mq[$];
  int   m_mpc, m_ovf, m_unf;
  bit   m_valid = 0;
  int   m_t;

  always @(posedge clk) begin
    if (rst) begin
      m_mpc = 0; m_ovf = 0; m_unf = 0; mq.delete(); m_valid = 1;
    end else if (bus.advance) begin
      m_t = int'(bus.ADDR) | (bus.JNZC[0] ? int'(bus.inMBR) : 0);
      if ((bus.JNZC[2] && bus.N) || (bus.JNZC[1] && bus.Z)) m_t = m_t | 'h100;
      case (bus.SEQ_OP)
        2'd0: m_mpc = m_t;
        2'd1: begin
          if (mq.size() < SD) mq.push_back(int'(bus.LINK)); else m_ovf = 1;
          m_mpc = m_t;
        end
        2'd2: begin
          if (mq.size() > 0) m_mpc = mq.pop_back();
          else begin m_mpc = 0; m_unf = 1; end
        end
        default: begin mq.delete(); m_ovf = 0; m_unf = 0; m_mpc = m_t; end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_mpc", int'(bus.outMPC), m_mpc);
      chk("model_sp",  int'(bus.sp), mq.size());
      chk("model_ovf", int'(bus.stack_ovf), m_ovf);
      chk("model_unf", int'(bus.stack_unf), m_unf);
    end
  end

  // Apply one cycle of inputs, then land 1 time unit after the edge.
  task automatic drv(input logic adv, input logic [1:0] op, input logic [8:0] addr,
                     input logic [2:0] jnzc, input logic n, input logic z,
                     input logic [7:0] mbr, input logic [8:0] link);
    bus.advance = adv; bus.SEQ_OP = op; bus.ADDR = addr; bus.JNZC = jnzc;
    bus.N = n; bus.Z = z; bus.inMBR = mbr; bus.LINK = link;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string name, input int mpc, input int sp, input int ovf, input int unf);
    chk({name, "_mpc"}, int'(bus.outMPC), mpc);
    chk({name, "_sp"},  int'(bus.sp), sp);
    chk({name, "_ovf"}, int'(bus.stack_ovf), ovf);
    chk({name, "_unf"}, int'(bus.stack_unf), unf);
  endtask

  initial begin
    // reset with advance high and a loud ADDR
    rst = 1'b1;
    drv(1, 2'd0, 9'h1FF, 3'b111, 1, 1, 8'hFF, 9'h1FF);
    st("reset", 'h000, 0, 0, 0);
    rst = 1'b0;

    // hold: advance low, inputs churning
    drv(0, 2'd1, 9'h123, 3'b001, 1, 0, 8'h55, 9'h0AA); st("hold0", 'h000, 0, 0, 0);
    drv(0, 2'd2, 9'h0F0, 3'b110, 0, 1, 8'h0F, 9'h011); st("hold1", 'h000, 0, 0, 0);
    drv(0, 2'd3, 9'h1FF, 3'b111, 1, 1, 8'hFF, 9'h1FF); st("hold2", 'h000, 0, 0, 0);

    // JMPC / JAM target formation
    drv(1, 2'd0, 9'h100, 3'b001, 0, 0, 8'h60, 9'h000); chk("jmpc",     int'(bus.outMPC), 'h160);
    drv(1, 2'd0, 9'h012, 3'b010, 0, 1, 8'h00, 9'h000); chk("jamz_1",   int'(bus.outMPC), 'h112);
    drv(1, 2'd0, 9'h012, 3'b010, 0, 0, 8'h00, 9'h000); chk("jamz_0",   int'(bus.outMPC), 'h012);
    drv(1, 2'd0, 9'h000, 3'b101, 1, 0, 8'h0A, 9'h000); chk("jamn_jmpc",int'(bus.outMPC), 'h10A);

    // nested call / return; RET ignores ADDR and JNZC
    drv(1, 2'd1, 9'h050, 3'b000, 0, 0, 8'h00, 9'h020); st("call1", 'h050, 1, 0, 0);
    drv(1, 2'd1, 9'h080, 3'b000, 0, 0, 8'h00, 9'h060); st("call2", 'h080, 2, 0, 0);
    drv(1, 2'd2, 9'h1FF, 3'b111, 1, 1, 8'hFF, 9'h000); st("ret1",  'h060, 1, 0, 0);
    drv(1, 2'd2, 9'h1FF, 3'b111, 1, 1, 8'hFF, 9'h000); st("ret2",  'h020, 0, 0, 0);

    // overflow: fourth CALL fills cleanly, fifth overflows
    for (int i = 1; i <= 5; i++) begin
      drv(1, 2'd1, 9'(i * 16), 3'b000, 0, 0, 8'h00, 9'(i));
      st($sformatf("ovf_call%0d", i), i * 16, (i > SD) ? SD : i, (i > SD) ? 1 : 0, 0);
    end
    for (int i = 4; i >= 1; i--) begin
      drv(1, 2'd2, 9'h000, 3'b000, 0, 0, 8'h00, 9'h000);
      st($sformatf("ovf_ret%0d", i), i, i - 1, 1, 0);
    end

    // underflow, sticky through NONE, cleared by FLUSH
    drv(1, 2'd2, 9'h077, 3'b000, 0, 0, 8'h00, 9'h000); st("unf_ret",   'h000, 0, 1, 1);
    drv(1, 2'd0, 9'h033, 3'b000, 0, 0, 8'h00, 9'h000); st("unf_stick", 'h033, 0, 1, 1);
    drv(1, 2'd3, 9'h044, 3'b000, 0, 0, 8'h00, 9'h000); st("flush",     'h044, 0, 0, 0);

    // stalled CALL commits exactly once
    drv(0, 2'd1, 9'h0BB, 3'b000, 0, 0, 8'h00, 9'h0AA); st("stall0", 'h044, 0, 0, 0);
    drv(0, 2'd1, 9'h0BB, 3'b000, 0, 0, 8'h00, 9'h0AA); st("stall1", 'h044, 0, 0, 0);
    drv(1, 2'd1, 9'h0BB, 3'b000, 0, 0, 8'h00, 9'h0AA); st("stall_go", 'h0BB, 1, 0, 0);
    drv(0, 2'd2, 9'h000, 3'b000, 0, 0, 8'h00, 9'h000); st("stall_hold", 'h0BB, 1, 0, 0);
    drv(1, 2'd2, 9'h000, 3'b000, 0, 0, 8'h00, 9'h000); st("stall_ret", 'h0AA, 0, 0, 0);

    // reset inside a subroutine drops the pending return
    drv(1, 2'd1, 9'h0DD, 3'b000, 0, 0, 8'h00, 9'h0CC); st("sub_call", 'h0DD, 1, 0, 0);
    rst = 1'b1;
    drv(1, 2'd1, 9'h0EE, 3'b000, 0, 0, 8'h00, 9'h0FF); st("sub_rst", 'h000, 0, 0, 0);
    rst = 1'b0;
    drv(1, 2'd2, 9'h000, 3'b000, 0, 0, 8'h00, 9'h000); st("sub_ret", 'h000, 0, 0, 1);

    drv(0, 2'd0, 9'h000, 3'b000, 0, 0, 8'h00, 9'h000);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
